// File: rtl/ldmac_key_schedule.sv
// LDMAC key schedule: latches a 128-bit master key and streams 32-bit round keys.
// Optional LDMAC_KS_REWIND_EN adds a rewind input that replays the last loaded key.
module ldmac_key_schedule #(
    parameter int NUM_ROUNDS = 16,
    parameter int CW         = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [127:0]  key_in,
    input  logic          key_load,
    output logic          key_ready,
    input  logic          abort,
`ifdef LDMAC_KS_REWIND_EN
    input  logic          rewind,
`endif
    output logic [31:0]   rk_out,
    output logic [CW-1:0] rk_idx,
    output logic          rk_valid,
    input  logic          rk_ready,
    output logic          done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [CW-1:0] LAST = CW'(NUM_ROUNDS - 1);

    state_e         state_q, state_d;
    logic [127:0]   s_q, s_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;
    logic [127:0]   u_s;

`ifdef LDMAC_KS_REWIND_EN
    logic [127:0]   shadow_q, shadow_d;
    logic           loaded_q, loaded_d;
`endif

    // Word shift down plus the two half-word rotations of s0 into s3
    always_comb begin
        u_s = {s_q[17:16], s_q[31:18], s_q[11:0], s_q[15:12], s_q[127:32]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            s_d     = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (key_load) begin
                        s_d     = key_in;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
`ifdef LDMAC_KS_REWIND_EN
                    else if (rewind && loaded_q) begin
                        s_d     = shadow_q;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
`endif
                end
                RUN: begin
`ifdef LDMAC_KS_REWIND_EN
                    if (rewind) begin
                        s_d   = shadow_q;
                        cnt_d = '0;
                    end else
`endif
                    if (rk_ready) begin
                        if (cnt_q == LAST) begin
                            done_d  = 1'b1;
                            s_d     = '0;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            s_d   = u_s;
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef LDMAC_KS_REWIND_EN
    always_comb begin
        shadow_d = shadow_q;
        loaded_d = loaded_q;
        if (!abort && state_q == IDLE && key_load) begin
            shadow_d = key_in;
            loaded_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            loaded_q <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            loaded_q <= loaded_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        key_ready = (state_q == IDLE);
        rk_valid  = (state_q == RUN);
        done      = done_q;
        rk_out    = s_q[31:0];
        rk_idx    = cnt_q;
    end

endmodule

// File: tb/tb_ldmac_key_schedule.sv
// Directed bench for ldmac_key_schedule with hand-computed round keys.
// Define LDMAC_KS_REWIND_EN to include the rewind check.
module tb_ldmac_key_schedule;

    localparam int NR = 16;
    localparam int CW = 6;

    logic          clk;
    logic          rst_n;
    logic [127:0]  key_in;
    logic          key_load;
    logic          key_ready;
    logic          abort;
    logic [31:0]   rk_out;
    logic [CW-1:0] rk_idx;
    logic          rk_valid;
    logic          rk_ready;
    logic          done;
`ifdef LDMAC_KS_REWIND_EN
    logic          rewind;
`endif

    int n_chk;
    int n_fail;

    ldmac_key_schedule #(
        .NUM_ROUNDS(NR),
        .CW        (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .key_load (key_load),
        .key_ready(key_ready),
        .abort    (abort),
`ifdef LDMAC_KS_REWIND_EN
        .rewind   (rewind),
`endif
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a key for one cycle; returns at the negedge showing idx 0
    task automatic load(input logic [127:0] k);
        @(negedge clk);
        key_in   = k;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    logic [127:0] k1;
    logic [31:0]  exp1 [5];

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        key_in   = '0;
        key_load = 1'b0;
        abort    = 1'b0;
        rk_ready = 1'b1;
`ifdef LDMAC_KS_REWIND_EN
        rewind   = 1'b0;
`endif
        k1 = {32'h33333333, 32'h22222222, 32'h11111111, 32'h0000000F};
        exp1[0] = 32'h0000000F;
        exp1[1] = 32'h11111111;
        exp1[2] = 32'h22222222;
        exp1[3] = 32'h33333333;
        exp1[4] = 32'h000000F0;

        #12;
        chk("rst_rk_valid", 128'(rk_valid), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_rk_out", 128'(rk_out), 128'd0);
        chk("rst_rk_idx", 128'(rk_idx), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_key_ready", 128'(key_ready), 128'd1);

        // Full-throughput schedule: 16 valid cycles then one done pulse
        load(k1);
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("run_valid%0d", i), 128'(rk_valid), 128'd1);
            chk($sformatf("run_idx%0d", i), 128'(rk_idx), 128'(i));
            chk($sformatf("run_done%0d", i), 128'(done), 128'd0);
            if (i < 5)
                chk($sformatf("run_rk%0d", i), 128'(rk_out), 128'(exp1[i]));
            @(negedge clk);
        end
        chk("end_done", 128'(done), 128'd1);
        chk("end_valid", 128'(rk_valid), 128'd0);
        @(negedge clk);
        chk("end_done_clr", 128'(done), 128'd0);
        chk("end_key_ready", 128'(key_ready), 128'd1);

        // Upper half-word rotate right by 2
        load({96'h0, 32'h00010000});
        repeat (4) @(negedge clk);
        chk("rot_idx4a", 128'(rk_idx), 128'd4);
        chk("rot_rk4a", 128'(rk_out), 128'h40000000);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        load({96'h0, 32'h00040000});
        repeat (4) @(negedge clk);
        chk("rot_rk4b", 128'(rk_out), 128'h00010000);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // Backpressure at idx 5 with a stray key_load during the stall
        load(k1);
        repeat (5) @(negedge clk);
        rk_ready = 1'b0;
        key_in   = {4{32'hDEADBEEF}};
        key_load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall_idx%0d", i), 128'(rk_idx), 128'd5);
            chk($sformatf("stall_rk%0d", i), 128'(rk_out), 128'h44441111);
            chk($sformatf("stall_kr%0d", i), 128'(key_ready), 128'd0);
            @(negedge clk);
        end
        chk("stall_idx_end", 128'(rk_idx), 128'd5);
        key_load = 1'b0;
        rk_ready = 1'b1;
        @(negedge clk);
        chk("post_idx6", 128'(rk_idx), 128'd6);
        chk("post_rk6", 128'(rk_out), 128'h88882222);

        // Abort at idx 7 outranks the handshake on the same cycle
        @(negedge clk);
        chk("abort_at_idx", 128'(rk_idx), 128'd7);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", 128'(rk_valid), 128'd0);
        chk("abort_done", 128'(done), 128'd0);
        chk("abort_key_ready", 128'(key_ready), 128'd1);
        chk("abort_idx", 128'(rk_idx), 128'd0);
        chk("abort_rk", 128'(rk_out), 128'd0);
        @(negedge clk);
        chk("abort_no_done", 128'(done), 128'd0);

        // Asynchronous reset in the middle of a schedule
        load(k1);
        repeat (3) @(negedge clk);
        chk("mid_idx3", 128'(rk_idx), 128'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(rk_valid), 128'd0);
        chk("arst_rk", 128'(rk_out), 128'd0);
        chk("arst_idx", 128'(rk_idx), 128'd0);
        chk("arst_done", 128'(done), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_key_ready", 128'(key_ready), 128'd1);

`ifdef LDMAC_KS_REWIND_EN
        load(k1);
        repeat (9) @(negedge clk);
        chk("rw_idx9", 128'(rk_idx), 128'd9);
        rewind = 1'b1;
        @(negedge clk);
        rewind = 1'b0;
        chk("rw_idx0", 128'(rk_idx), 128'd0);
        chk("rw_rk0", 128'(rk_out), 128'h0000000F);
        chk("rw_valid", 128'(rk_valid), 128'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ldmac_key_schedule.md
Name: ldmac_key_schedule

Overview:
- Sequential key-schedule stage feeding round keys to the LDMAC round function.
- Latches a 128-bit master key, then emits one 32-bit round key per accepted handshake.
- Between rounds, the 128-bit state advances by one application of the key-update permutation, defined in full below.
- Sits between the key-load interface and the round datapath.

Parameters:
NUM_ROUNDS, 16, round keys emitted per loaded key (2..64)
CW, 6, width of round index (must satisfy 2^CW >= NUM_ROUNDS)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
key_in  in  128  master key; word i = key_in[32i+31:32i]
key_load  in  1  master-key valid
key_ready  out  1  block can accept a key
abort  in  1  synchronous cancel of current schedule
rk_out  out  32  current round key
rk_idx  out  CW  index of rk_out (0..NUM_ROUNDS-1)
rk_valid  out  1  rk_out/rk_idx valid
rk_ready  in  1  consumer accepts round key
done  out  1  one-cycle pulse after last round key accepted

Behaviour:
- State S is 128 bits, words s0..s3 (s0 = S[31:0]).
- Update function U(S), pure combinational:
  - new s0 = s1, new s1 = s2, new s2 = s3.
  - new s3[15:0] = s0[15:0] rotated left by 4: bits [3:0] take s0[15:12], bits [15:4] take s0[11:0].
  - new s3[31:16] = s0[31:16] rotated right by 2: bits [29:16] take s0[31:18], bits [31:30] take s0[17:16].
- FSM states: IDLE, RUN.
- IDLE:
  - key_ready=1, rk_valid=0.
  - key_load=1 -> S<=key_in, cnt<=0, go RUN next cycle.
- RUN:
  - key_ready=0, rk_valid=1, rk_out=s0, rk_idx=cnt.
  - rk_valid&rk_ready with cnt<NUM_ROUNDS-1 -> S<=U(S), cnt<=cnt+1.
  - rk_valid&rk_ready with cnt==NUM_ROUNDS-1 -> done=1 for one cycle, S<=0, cnt<=0, go IDLE.
- Latency: first round key is valid the cycle after key acceptance. At full throughput (rk_ready held high), one key per cycle.
- Backpressure: while rk_valid=1 and rk_ready=0, rk_out and rk_idx hold stable.
- key_load during RUN is ignored; key_ready=0 makes the drop visible.
- abort=1 (any state):
  - Next cycle: IDLE, S=0, cnt=0, done not asserted.
  - abort has priority over the handshake and over key_load in the same cycle.
- Reset (async assert, sync release): state IDLE, S=0, cnt=0, rk_out=0, rk_idx=0, rk_valid=0, done=0, key_ready=1 after release.
- Reset mid-RUN discards the schedule immediately.
- Registered outputs: rk_valid, done, state. rk_out and rk_idx are direct register slices.

Optional Feature:
- Macro: LDMAC_KS_REWIND_EN.
- When defined:
  - Adds input rewind (1 bit) and a 128-bit shadow register that captures key_in on every accepted key_load.
  - rewind=1 in RUN, or in IDLE after at least one load -> S<=shadow, cnt<=0, state RUN. The same master key is re-emitted without reloading.
  - abort outranks rewind. Reset clears the shadow and its loaded flag.
  - rewind in IDLE with no prior load is ignored.
- When undefined: no rewind port, no shadow register; behaviour exactly as above.

Test Plan:
- Load with key_in words s0=0x0000000F, s1=0x11111111, s2=0x22222222, s3=0x33333333, rk_ready=1 -> rk_out sequence 0x0000000F, 0x11111111, 0x22222222, 0x33333333, 0x000000F0 with idx 0..4.
- Load s0=0x00010000, others 0 -> rk4=0x40000000; s0=0x00040000 -> rk4=0x00010000.
- NUM_ROUNDS=16, rk_ready=1 -> exactly 16 rk_valid cycles, then done pulses once, then key_ready=1 the next cycle.
- Drop rk_ready for 3 cycles at idx 5 -> rk_out/rk_idx unchanged through the stall; idx 6 follows the next accept.
- key_load during RUN is ignored. abort at idx 7 -> IDLE next cycle, no done. rst_n low at idx 3 -> all outputs 0 immediately.
- With LDMAC_KS_REWIND_EN: rewind at idx 9 -> next rk_idx=0 and rk_out equals the original s0.
